// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder among NUM_REQ requesters.
// Optional FP_ARB_STALL_CNT_EN adds a saturating 16-bit count of back-pressured result cycles.

module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  // Leading-zero count of a 27-bit mantissa with guard/round/sticky.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  // Round-to-nearest-even on {hidden, frac[22:0], g, r, s}; returns {exp[9:0], frac[22:0]}.
  function automatic logic [32:0] round_rne(input logic [26:0] m, input logic [9:0] e);
    logic [24:0] r;
    logic        up;
    logic [9:0]  eo;
    logic [22:0] f;
    up = m[2] & (m[1] | m[0] | m[3]);
    r  = {1'b0, m[26:3]} + 25'(up);
    if (r[24]) begin
      eo = e + 10'd1;
      f  = r[23:1];
    end else begin
      eo = r[23] ? e : 10'd0;
      f  = r[22:0];
    end
    return {eo, f};
  endfunction

  // Overflowed exponents saturate to infinity.
  function automatic logic [31:0] pack(input logic sgn, input logic [32:0] rr);
    if (rr[32:23] >= 10'd255) return {sgn, 8'hFF, 23'd0};
    return {sgn, rr[30:0]};
  endfunction

  logic        swap, sub;
  logic [31:0] l, sm;
  logic [7:0]  el, es, diff, lim, shamt;
  logic [23:0] ml, ms;
  logic [49:0] sh;
  logic [26:0] ml27, ms27, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  e_n;
  logic [32:0] rr;

  always_comb begin
    swap  = b[30:0] > a[30:0];
    l     = swap ? b : a;
    sm    = swap ? a : b;
    el    = (l[30:23] == 8'd0) ? 8'd1 : l[30:23];
    es    = (sm[30:23] == 8'd0) ? 8'd1 : sm[30:23];
    ml    = {l[30:23] != 8'd0, l[22:0]};
    ms    = {sm[30:23] != 8'd0, sm[22:0]};
    diff  = el - es;
    sh    = {ms, 26'd0} >> diff;
    if (diff > 8'd26) ms27 = {26'd0, |ms};
    else              ms27 = {sh[49:24], |sh[23:0]};
    ml27  = {ml, 3'b000};
    sub   = l[31] ^ sm[31];
    sum   = sub ? ({1'b0, ml27} - {1'b0, ms27}) : ({1'b0, ml27} + {1'b0, ms27});
    lz    = lzc27(sum[26:0]);
    // Left shift stops at exponent 1 so tiny results land as subnormals.
    lim   = el - 8'd1;
    shamt = ({3'b000, lz} < lim) ? {3'b000, lz} : lim;
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e_n  = {2'b00, el} + 10'd1;
    end else begin
      norm = sum[26:0] << shamt;
      e_n  = {2'b00, el} - {2'b00, shamt};
    end
    rr = round_rne(norm, e_n);
    if (sum == 28'd0) s = {sub ? 1'b0 : l[31], 31'd0};
    else              s = pack(l[31], rr);
  end
endmodule

module fp_add_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_s,
`ifdef FP_ARB_STALL_CNT_EN
  output logic [15:0]          stall_cnt,
`endif
  output logic [ID_W-1:0]      res_id
);
  // First valid index at or after p, wrapping; MSB flags that one was found.
  function automatic logic [ID_W:0] find_grant(input logic [NUM_REQ-1:0] v,
                                               input logic [ID_W-1:0] p);
    logic [ID_W:0] r;
    int idx;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (v[idx]) r = {1'b1, ID_W'(idx)};
    end
    return r;
  endfunction

  logic [ID_W-1:0] ptr, gnt;
  logic [ID_W:0]   sel;
  logic            can_accept, grant;
  logic [31:0]     op_a, op_b, sum;

  always_comb begin
    can_accept = !res_valid || res_ready;
    sel        = find_grant(req_valid, ptr);
    gnt        = sel[ID_W-1:0];
    grant      = can_accept && sel[ID_W] && !rst;
    req_ready  = grant ? (NUM_REQ'(1) << gnt) : '0;
    op_a       = req_a[32*gnt +: 32];
    op_b       = req_b[32*gnt +: 32];
  end

  fp_adder u_add (.a(op_a), .b(op_b), .s(sum));

  // Result register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_s     <= 32'h0;
      res_id    <= '0;
      ptr       <= '0;
    end else if (grant) begin
      res_valid <= 1'b1;
      res_s     <= sum;
      res_id    <= gnt;
      ptr       <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef FP_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= 16'h0;
    else if (res_valid && !res_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule
